// File: rtl/rr_arbiter8.sv
// -----------------------------------------------------------------------------
// rr_arbiter8
// Round-robin arbiter that shares one downstream resource among 8 requesters.
// A grant is held until the owner pulses done or drops its request. After the
// release there is one dead cycle, and then the next owner is chosen. The
// search starts just after the last owner, so the last owner has the lowest
// priority in the next arbitration.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When it is defined, a hold counter forces a release after MAX_HOLD grant
//   cycles and pulses timeout for that one cycle.
//   When it is undefined, no counter is built and timeout is tied to 0.
//
// Parameters:
//   MAX_HOLD   maximum grant duration in cycles (2..255). It is used only
//              with ARB_TIMEOUT_EN.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req[7:0]   level-sensitive request lines
//   done       single-cycle release pulse from the current owner
//   gnt[7:0]   registered one-hot grant
//   gnt_id     registered binary index of the owner (kept after release)
//   gnt_valid  registered, always equal to |gnt
//   timeout    registered single-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] MAX_HOLD_B = 8'(MAX_HOLD);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [2:0] ptr_r;
    logic [2:0] ptr_nxt_s;
    logic [7:0] gnt_r;
    logic [7:0] gnt_nxt_s;
    logic [2:0] gnt_id_r;
    logic [2:0] gnt_id_nxt_s;
    logic       gnt_valid_r;
    logic       gnt_valid_nxt_s;
    logic       timeout_r;
    logic       timeout_nxt_s;

    logic       win_found_s;
    logic [2:0] win_idx_s;
    logic       release_s;
    logic       limit_s;
    logic       force_s;

    // Round-robin search that starts at p+1 and wraps, so p itself is checked last.
    // The loop runs from the farthest offset down to the nearest offset. The
    // nearest set bit is written last, so it wins. The result is {found, index}.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int i = 8; i >= 1; i--) begin
            idx = p + 3'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign {win_found_s, win_idx_s} = rr_pick(req, ptr_r);

    // A normal release is done or the owner dropping its request. If both
    // happen in the same cycle, it is still one release.
    assign release_s = done | ~req[gnt_id_r];

    // A forced release happens only when no normal release is pending.
    assign force_s = (state_r == BUSY) & ~release_s & limit_s;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt_r;
    logic [7:0] hold_cnt_nxt_s;

    assign limit_s = (hold_cnt_r == (MAX_HOLD_B - 8'd1));

    // Hold counter: it stays at zero outside a grant and counts each BUSY cycle.
    always_comb begin
        hold_cnt_nxt_s = hold_cnt_r;
        case (state_r)
            IDLE: hold_cnt_nxt_s = 8'd0;
            BUSY: begin
                if (release_s || force_s) begin
                    hold_cnt_nxt_s = 8'd0;
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r + 8'd1;
                end
            end
            default: hold_cnt_nxt_s = 8'd0;
        endcase
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r <= 8'd0;
        end else begin
            hold_cnt_r <= hold_cnt_nxt_s;
        end
    end
`else
    logic unused_max_hold_s;

    assign limit_s           = 1'b0;
    assign unused_max_hold_s = ^MAX_HOLD_B;
`endif

    // State, pointer and output registers. Reset clears them asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ptr_r       <= 3'd7;
            gnt_r       <= 8'h00;
            gnt_id_r    <= 3'd0;
            gnt_valid_r <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            ptr_r       <= ptr_nxt_s;
            gnt_r       <= gnt_nxt_s;
            gnt_id_r    <= gnt_id_nxt_s;
            gnt_valid_r <= gnt_valid_nxt_s;
            timeout_r   <= timeout_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (win_found_s) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (release_s || force_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values of the registered outputs and of the pointer.
    // gnt_id keeps its value on release. The pointer takes the owner's index,
    // so that owner has the lowest priority in the next search.
    always_comb begin
        gnt_nxt_s     = gnt_r;
        gnt_id_nxt_s  = gnt_id_r;
        ptr_nxt_s     = ptr_r;
        timeout_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (win_found_s) begin
                    gnt_nxt_s    = 8'd1 << win_idx_s;
                    gnt_id_nxt_s = win_idx_s;
                end else begin
                    gnt_nxt_s    = 8'h00;
                end
            end
            BUSY: begin
                if (release_s || force_s) begin
                    gnt_nxt_s     = 8'h00;
                    ptr_nxt_s     = gnt_id_r;
                    timeout_nxt_s = force_s;
                end else begin
                    gnt_nxt_s     = gnt_r;
                end
            end
            default: begin
                gnt_nxt_s    = 8'h00;
                gnt_id_nxt_s = 3'd0;
                ptr_nxt_s    = 3'd7;
            end
        endcase
        gnt_valid_nxt_s = |gnt_nxt_s;
    end

    assign gnt       = gnt_r;
    assign gnt_id    = gnt_id_r;
    assign gnt_valid = gnt_valid_r;
    assign timeout   = timeout_r;

endmodule
